// File: rtl/mnist_pixel_feeder.sv
// Ping-pong frame buffer that streams one INPUT_SIZE x INPUT_SIZE frame in raster
// order as a single-channel vld/din pixel stream, with programmable idle gaps.
module mnist_pixel_feeder #(
    parameter int N          = 8,
    parameter int INPUT_SIZE = 28,
    parameter int GAP        = 0,
    parameter int ROW_GAP    = 0,
    localparam int ADDR_W    = $clog2(INPUT_SIZE * INPUT_SIZE)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [N-1:0]      wr_data,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              start_err,
    output logic              input_vld,
    output logic [N-1:0]      input_din
);

    localparam int PIX  = INPUT_SIZE * INPUT_SIZE;
    localparam int CW   = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
    localparam int GMAX = (GAP + ROW_GAP > 1) ? (GAP + ROW_GAP) : 1;
    localparam int GW   = $clog2(GMAX + 1);

    localparam logic [ADDR_W:0] PIX_W   = (ADDR_W + 1)'(PIX);
    localparam logic [CW-1:0]   LAST    = CW'(INPUT_SIZE - 1);
    localparam logic [GW-1:0]   W_COL   = GW'(GAP);
    localparam logic [GW-1:0]   W_ROW   = GW'(GAP + ROW_GAP);

    typedef enum logic [2:0] {IDLE, PREFETCH, EMIT, WAIT, FIN} state_t;

    state_t              state;
    logic                bank_sel;
    logic [CW-1:0]       row;
    logic [CW-1:0]       col;
    logic [ADDR_W-1:0]   addr;
    logic [GW-1:0]       gap_cnt;
    logic [ADDR_W-1:0]   rd_addr;
    logic [N-1:0]        rd_data;
    logic                last_pix;
    logic [GW-1:0]       wait_cnt;

    logic [N-1:0] mem [0:1][0:PIX-1];

    assign last_pix = (row == LAST) && (col == LAST);
    assign wait_cnt = (col == LAST) ? W_ROW : W_COL;

    // rd_data always holds the pixel at addr by the time EMIT consumes it,
    // so EMIT looks one address ahead and WAIT simply re-reads addr.
    always_comb begin
        rd_addr = addr;
        if (state == PREFETCH)
            rd_addr = '0;
        else if (state == EMIT && !last_pix)
            rd_addr = addr + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (wr_en && ({1'b0, wr_addr} < PIX_W))
            mem[bank_sel][wr_addr] <= wr_data;
        rd_data <= mem[~bank_sel][rd_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bank_sel  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            start_err <= 1'b0;
            input_vld <= 1'b0;
            input_din <= '0;
            row       <= '0;
            col       <= '0;
            addr      <= '0;
            gap_cnt   <= '0;
        end else begin
            done      <= 1'b0;
            start_err <= start && (state != IDLE);
            input_vld <= 1'b0;
            input_din <= '0;
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (start) begin
                        bank_sel <= ~bank_sel;
                        row      <= '0;
                        col      <= '0;
                        addr     <= '0;
                        busy     <= 1'b1;
                        state    <= PREFETCH;
                    end
                end
                PREFETCH: state <= EMIT;
                EMIT: begin
                    input_vld <= 1'b1;
                    input_din <= rd_data;
                    if (last_pix) begin
                        state <= FIN;
                    end else begin
                        addr <= addr + 1'b1;
                        if (col == LAST) begin
                            col <= '0;
                            row <= row + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                        if (wait_cnt == '0) begin
                            state <= EMIT;
                        end else begin
                            gap_cnt <= wait_cnt;
                            state   <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (gap_cnt == GW'(1))
                        state <= EMIT;
                    else
                        gap_cnt <= gap_cnt - 1'b1;
                end
                FIN: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
